trigger_detector: RTL and testbench

//  Parametrised successor of the single-polarity crossing detector in the buffer controller.

---
 rtl/trigger_detector_if.sv | 46 ++++
 rtl/trigger_detector.sv | 153 +++++++++++++++
 tb/tb_trigger_detector.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_detector_if.sv
`default_nettype none
// ============================================================================
// Module   : trigger_detector_if
// Brief    : Configuration, sample and trigger-result bundle for trigger_detector.
//            The holdoff signal exists only when TRIGGER_HOLDOFF_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface trigger_detector_if #(
   parameter int BITS_ADC  = 8,
   parameter int BITS_HYST = 4,
   parameter int BITS_HOLD = 16
);
   logic                 en;
   logic [1:0]           edge_sel;
   logic [BITS_ADC-1:0]  trigger_value;
   logic [BITS_HYST-1:0] hysteresis;
   logic [BITS_ADC-1:0]  input_sample;
   logic                 input_rdy;
`ifdef TRIGGER_HOLDOFF_EN
   logic [BITS_HOLD-1:0] holdoff;
`endif
   logic                 triggered;
   logic                 edge_dir;
   logic                 armed;

   if (BITS_ADC < 1 || BITS_HYST < 1 || BITS_HOLD < 1) begin : g_param_check
      $error("trigger_detector_if: widths must be at least 1");
   end

   modport master (
`ifdef TRIGGER_HOLDOFF_EN
      output holdoff,
`endif
      output en, edge_sel, trigger_value, hysteresis, input_sample, input_rdy,
      input  triggered, edge_dir, armed
   );

   modport slave (
`ifdef TRIGGER_HOLDOFF_EN
      input  holdoff,
`endif
      input  en, edge_sel, trigger_value, hysteresis, input_sample, input_rdy,
      output triggered, edge_dir, armed
   );
endinterface
`default_nettype wire

// File: rtl/trigger_detector.sv
`default_nettype none
// ============================================================================
// Module   : trigger_detector
// Brief    : Threshold-crossing detector with hysteresis and runtime edge select.
//            Optional post-trigger holdoff enabled by macro TRIGGER_HOLDOFF_EN.
// Revision : 1.0  initial release
// ============================================================================
module trigger_detector #(
   parameter int BITS_ADC  = 8,
   parameter int BITS_HYST = 4,
   parameter int BITS_HOLD = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   trigger_detector_if.slave  bus
);
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SEARCHING = 3'd1;
   localparam logic [2:0] ST_VALID_POS = 3'd2;
   localparam logic [2:0] ST_VALID_NEG = 3'd3;
`ifdef TRIGGER_HOLDOFF_EN
   localparam logic [2:0] ST_HOLDOFF   = 3'd4;
`endif

   localparam logic [1:0] c_sel_pos  = 2'd0;
   localparam logic [1:0] c_sel_neg  = 2'd1;
   localparam logic [1:0] c_sel_both = 2'd2;
   localparam logic [1:0] c_sel_off  = 2'd3;

   if (BITS_ADC < 1 || BITS_HYST < 1 || BITS_HOLD < 1) begin : g_param_check
      $error("trigger_detector: widths must be at least 1");
   end

   logic [2:0]          r_state;
   logic [2:0]          w_next_state;
   logic [1:0]          r_edge_sel;
   logic [BITS_ADC-1:0] w_hyst;
   logic [BITS_ADC:0]   w_sum;
   logic [BITS_ADC-1:0] w_lo;
   logic [BITS_ADC-1:0] w_hi;
   logic                w_cfg_ok;
   logic                w_pos_mode;
   logic                w_neg_mode;
   logic                w_fire;
   logic                w_fire_dir;
   logic                r_triggered;
   logic                r_edge_dir;
   logic                r_armed;
`ifdef TRIGGER_HOLDOFF_EN
   logic [BITS_HOLD-1:0] r_hold_cnt;
`endif

   // Saturating hysteresis window around the threshold
   assign w_hyst = BITS_ADC'(bus.hysteresis);
   assign w_sum  = {1'b0, bus.trigger_value} + {1'b0, w_hyst};
   assign w_hi   = w_sum[BITS_ADC] ? {BITS_ADC{1'b1}} : w_sum[BITS_ADC-1:0];
   assign w_lo   = (bus.trigger_value < w_hyst) ? '0 : (bus.trigger_value - w_hyst);

   // A disabled detector or any edge_sel change since last clock drops back to idle
   assign w_cfg_ok   = bus.en && (bus.edge_sel != c_sel_off) && (bus.edge_sel == r_edge_sel);
   assign w_pos_mode = (r_edge_sel == c_sel_pos) || (r_edge_sel == c_sel_both);
   assign w_neg_mode = (r_edge_sel == c_sel_neg) || (r_edge_sel == c_sel_both);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_edge_sel <= c_sel_pos;
      end else begin
         r_state    <= w_next_state;
         r_edge_sel <= bus.edge_sel;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (!w_cfg_ok) begin
         w_next_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: w_next_state = ST_SEARCHING;
            ST_SEARCHING: begin
               if (bus.input_rdy) begin
                  if (w_pos_mode && (bus.input_sample < w_lo))
                     w_next_state = ST_VALID_POS;
                  else if (w_neg_mode && (bus.input_sample > w_hi))
                     w_next_state = ST_VALID_NEG;
               end
            end
            ST_VALID_POS, ST_VALID_NEG: begin
               if (w_fire) begin
`ifdef TRIGGER_HOLDOFF_EN
                  w_next_state = (bus.holdoff != '0) ? ST_HOLDOFF : ST_SEARCHING;
`else
                  w_next_state = ST_SEARCHING;
`endif
               end
            end
`ifdef TRIGGER_HOLDOFF_EN
            ST_HOLDOFF: begin
               if (bus.input_rdy && (r_hold_cnt <= BITS_HOLD'(1)))
                  w_next_state = ST_SEARCHING;
            end
`endif
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_fire     = 1'b0;
      w_fire_dir = 1'b0;
      if (w_cfg_ok && bus.input_rdy) begin
         if ((r_state == ST_VALID_POS) && (bus.input_sample >= bus.trigger_value)) begin
            w_fire = 1'b1;
         end else if ((r_state == ST_VALID_NEG) && (bus.input_sample <= bus.trigger_value)) begin
            w_fire     = 1'b1;
            w_fire_dir = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_triggered <= 1'b0;
         r_edge_dir  <= 1'b0;
         r_armed     <= 1'b0;
      end else begin
         r_triggered <= w_fire;
         if (w_fire)
            r_edge_dir <= w_fire_dir;
         r_armed <= (w_next_state == ST_VALID_POS) || (w_next_state == ST_VALID_NEG);
      end
   end

`ifdef TRIGGER_HOLDOFF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_hold_cnt <= '0;
      else if (!w_cfg_ok)
         r_hold_cnt <= '0;
      else if (w_fire)
         r_hold_cnt <= bus.holdoff;
      else if ((r_state == ST_HOLDOFF) && bus.input_rdy && (r_hold_cnt != '0))
         r_hold_cnt <= r_hold_cnt - BITS_HOLD'(1);
   end
`endif

   assign bus.triggered = r_triggered;
   assign bus.edge_dir  = r_edge_dir;
   assign bus.armed     = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_trigger_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_trigger_detector
// Brief    : Self-checking bench for trigger_detector: vector table, corner
//            sequences and randomized traffic against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_trigger_detector;
   localparam int BITS_ADC  = 8;
   localparam int BITS_HYST = 4;
   localparam int BITS_HOLD = 16;
   localparam int MAXV      = (1 << BITS_ADC) - 1;

   localparam int M_IDLE = 0, M_SEARCH = 1, M_ARM_POS = 2, M_ARM_NEG = 3, M_HOLD = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   trigger_detector_if #(.BITS_ADC(BITS_ADC), .BITS_HYST(BITS_HYST), .BITS_HOLD(BITS_HOLD)) bus ();

   trigger_detector #(.BITS_ADC(BITS_ADC), .BITS_HYST(BITS_HYST), .BITS_HOLD(BITS_HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       en;
      logic [1:0] sel;
      logic [7:0] t;
      logic [3:0] h;
      logic [7:0] s;
      logic       rdy;
      logic       trig;
      logic       dir;
      logic       armed;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   // behavioural model state
   int m_mode, m_prev_sel, m_hold;
   bit m_trig, m_dir, m_armed;

   function automatic vec_t mk(int en, int sel, int t, int h, int s, int rdy,
                               int trig, int dir, int armed);
      vec_t v;
      v.en = en[0]; v.sel = sel[1:0]; v.t = t[7:0]; v.h = h[3:0];
      v.s = s[7:0]; v.rdy = rdy[0];
      v.trig = trig[0]; v.dir = dir[0]; v.armed = armed[0];
      return v;
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int en, input int sel, input int t, input int h,
                        input int s, input int rdy);
      bus.en            = en[0];
      bus.edge_sel      = sel[1:0];
      bus.trigger_value = t[7:0];
      bus.hysteresis    = h[3:0];
      bus.input_sample  = s[7:0];
      bus.input_rdy     = rdy[0];
   endtask

   function automatic int hold_value();
`ifdef TRIGGER_HOLDOFF_EN
      return int'(bus.holdoff);
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_prev_sel = 0; m_hold = 0;
      m_trig = 0; m_dir = 0; m_armed = 0;
   endtask

   // One clock of the specified behaviour, using the inputs present at the edge
   task automatic model_step();
      int  t, h, s, sel, lo, hi;
      bit  ok, fire;
      t   = int'(bus.trigger_value);
      h   = int'(bus.hysteresis);
      s   = int'(bus.input_sample);
      sel = int'(bus.edge_sel);
      lo  = (t - h < 0) ? 0 : t - h;
      hi  = (t + h > MAXV) ? MAXV : t + h;
      ok  = bus.en && sel != 3 && sel == m_prev_sel;
      fire = 0;
      if (!ok) begin
         m_mode = M_IDLE;
         m_hold = 0;
      end else if (m_mode == M_IDLE) begin
         m_mode = M_SEARCH;
      end else if (bus.input_rdy) begin
         case (m_mode)
            M_SEARCH: begin
               if ((sel == 0 || sel == 2) && s < lo)      m_mode = M_ARM_POS;
               else if ((sel == 1 || sel == 2) && s > hi) m_mode = M_ARM_NEG;
            end
            M_ARM_POS: if (s >= t) begin fire = 1; m_dir = 0; end
            M_ARM_NEG: if (s <= t) begin fire = 1; m_dir = 1; end
            M_HOLD: begin
               m_hold--;
               if (m_hold <= 0) begin m_hold = 0; m_mode = M_SEARCH; end
            end
            default: m_mode = M_IDLE;
         endcase
      end
      if (fire) begin
         m_hold = hold_value();
         m_mode = (m_hold > 0) ? M_HOLD : M_SEARCH;
      end
      m_prev_sel = sel;
      m_trig     = fire;
      m_armed    = (m_mode == M_ARM_POS) || (m_mode == M_ARM_NEG);
   endtask

   // Clock the DUT and model together, then compare away from the edge
   task automatic step_check(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk({tag, ".triggered"}, bus.triggered, m_trig);
      chk({tag, ".armed"}, bus.armed, m_armed);
      if (m_trig) chk({tag, ".edge_dir"}, bus.edge_dir, m_dir);
   endtask

   vec_t tbl[25];

   initial begin
      int n_trig;
      int t_r, h_r, sel_r, s_r;

      tbl[0]  = mk(1,0,128,0,  0,0, 0,0,0);
      tbl[1]  = mk(1,0,128,0,100,1, 0,0,1);
      tbl[2]  = mk(1,0,128,0,130,1, 1,0,0);
      tbl[3]  = mk(1,0,128,0,130,0, 0,0,0);
      tbl[4]  = mk(1,0,128,8,125,1, 0,0,0);
      tbl[5]  = mk(1,0,128,8,130,1, 0,0,0);
      tbl[6]  = mk(1,0,128,8,119,1, 0,0,1);
      tbl[7]  = mk(1,0,128,8,127,1, 0,0,1);
      tbl[8]  = mk(1,0,128,8,128,1, 1,0,0);
      tbl[9]  = mk(1,2,128,8,  0,0, 0,0,0);
      tbl[10] = mk(1,2,128,8,  0,0, 0,0,0);
      tbl[11] = mk(1,2,128,8,140,1, 0,0,1);
      tbl[12] = mk(1,2,128,8,120,1, 1,1,0);
      tbl[13] = mk(1,2,128,8,130,1, 0,1,0);
      tbl[14] = mk(1,2,128,8,110,1, 0,1,1);
      tbl[15] = mk(1,2,128,8,129,1, 1,0,0);
      tbl[16] = mk(1,0,128,0,  0,0, 0,0,0);
      tbl[17] = mk(1,0,128,0,  0,0, 0,0,0);
      tbl[18] = mk(1,0,128,0,100,1, 0,0,1);
      tbl[19] = mk(1,1,128,0,200,1, 0,0,0);
      tbl[20] = mk(1,1,128,0,200,1, 0,0,0);
      tbl[21] = mk(0,1,128,0,200,0, 0,0,0);
      tbl[22] = mk(1,1,128,0,200,0, 0,0,0);
      tbl[23] = mk(1,1,128,0,200,1, 0,0,1);
      tbl[24] = mk(0,1,128,0, 50,1, 0,0,0);

      rst = 1'b0;
      drive(0, 0, 128, 0, 0, 0);
`ifdef TRIGGER_HOLDOFF_EN
      bus.holdoff = '0;
`endif
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset.triggered", bus.triggered, 1'b0);
      chk("reset.edge_dir", bus.edge_dir, 1'b0);
      chk("reset.armed", bus.armed, 1'b0);
      rst = 1'b1;

      // Vector table: hand-derived expectations
      for (int i = 0; i < 25; i++) begin
         drive(int'(tbl[i].en), int'(tbl[i].sel), int'(tbl[i].t), int'(tbl[i].h),
               int'(tbl[i].s), int'(tbl[i].rdy));
         @(posedge clk);
         model_step();
         @(negedge clk);
         chk($sformatf("tbl%0d.triggered", i), bus.triggered, tbl[i].trig);
         chk($sformatf("tbl%0d.armed", i), bus.armed, tbl[i].armed);
         if (tbl[i].trig) chk($sformatf("tbl%0d.edge_dir", i), bus.edge_dir, tbl[i].dir);
      end

      // Asynchronous reset while armed after a negative trigger
      drive(1, 1, 128, 0, 0, 0);   step_check("rst_seq");
      drive(1, 1, 128, 0, 200, 1); step_check("rst_seq");
      drive(1, 1, 128, 0, 50, 1);  step_check("rst_seq");
      drive(1, 1, 128, 0, 200, 1); step_check("rst_seq");
      chk("pre_rst.armed", bus.armed, 1'b1);
      chk("pre_rst.edge_dir", bus.edge_dir, 1'b1);
      rst = 1'b0;
      #1;
      chk("async_rst.triggered", bus.triggered, 1'b0);
      chk("async_rst.edge_dir", bus.edge_dir, 1'b0);
      chk("async_rst.armed", bus.armed, 1'b0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;

      // Saturated thresholds never arm
      n_trig = 0;
      for (int pass = 0; pass < 3; pass++) begin
         t_r   = (pass == 0) ? 0 : (pass == 1) ? MAXV : 4;
         h_r   = (pass == 2) ? 8 : 4;
         sel_r = (pass == 1) ? 1 : 0;
         for (int k = 0; k < 2 * MAXV + 4; k++) begin
            s_r = (k <= MAXV) ? k : ((2 * MAXV - k < 0) ? 0 : 2 * MAXV - k);
            drive(1, sel_r, t_r, h_r, s_r, 1);
            step_check("sat");
            if (bus.triggered) n_trig++;
         end
      end
      n_vec++;
      if (n_trig != 0) begin
         n_err++;
         $display("FAIL saturated_no_trigger: got %0d triggers expected 0", n_trig);
      end

`ifdef TRIGGER_HOLDOFF_EN
      bus.holdoff = 16'd3;
      for (int k = 0; k < 60; k++) begin
         drive(1, 0, 128, 0, (k % 2 == 0) ? 50 : 200, 1);
         step_check("holdoff");
      end
      bus.holdoff = '0;
`endif

      // Randomized traffic against the model
      t_r = 128; h_r = 4; sel_r = 2;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 49) == 0) t_r = int'($urandom_range(0, MAXV));
         if ($urandom_range(0, 49) == 0) h_r = int'($urandom_range(0, 15));
         if ($urandom_range(0, 59) == 0) sel_r = int'($urandom_range(0, 3));
`ifdef TRIGGER_HOLDOFF_EN
         if ($urandom_range(0, 99) == 0) bus.holdoff = 16'($urandom_range(0, 5));
`endif
         if ($urandom_range(0, 7) == 0)
            s_r = int'($urandom_range(0, MAXV));
         else begin
            s_r = t_r + int'($urandom_range(0, 48)) - 24;
            if (s_r < 0) s_r = 0;
            if (s_r > MAXV) s_r = MAXV;
         end
         drive(($urandom_range(0, 39) != 0) ? 1 : 0, sel_r, t_r, h_r, s_r,
               ($urandom_range(0, 3) != 0) ? 1 : 0);
         step_check("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
